cmd_sequencer: RTL and testbench
================================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 64, width of one command word read from the command buffer.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the master data bus.
REQ-003 SHALL have parameter TRANS_ADDR_WIDTH, default 8, width of the command-buffer word address.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, width of the master address bus.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a sequence; honoured only in IDLE.
REQ-008 SHALL have port start_addr, input, TRANS_ADDR_WIDTH, buffer word address of the first command; sampled with start.
REQ-009 SHALL have port cmd_rd_en, output, 1, command fetch request to the command buffer.
REQ-010 SHALL have port cmd_addr, output, TRANS_ADDR_WIDTH, buffer word address of the command being fetched.
REQ-011 SHALL have port cmd_rd_valid, input, 1, command buffer's indication that cmd_out is valid.
REQ-012 SHALL have port cmd_out, input, CMD_WIDTH, fetched command: [63:62] opcode, [61:32] word address, [31:0] data.
REQ-013 SHALL have ports mst_o_valid (output, 1), mst_o_addr (output, ADDR_WIDTH), mst_o_wr_data (output, DATA_WIDTH), and mst_o_rd0_wr1 (output, 1), together the master request.
REQ-014 SHALL have ports mst_i_ready (input, 1), mst_i_rd_data (input, DATA_WIDTH), and mst_i_rd_valid (input, 1), together the master response.
REQ-015 SHALL have ports busy (output, 1), done (output, 1), overflow (output, 1), cmd_count (output, 8), and last_rd_data (output, DATA_WIDTH), together the status.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT_CMD, ISSUE, WAIT_RD, DONE.
REQ-017 SHALL, in IDLE on start=1, load the fetch pointer from start_addr, clear cmd_count and overflow, and go to FETCH next cycle.
REQ-018 SHALL, in FETCH, drive cmd_rd_en=1 with cmd_addr=pointer for exactly one cycle, then enter WAIT_CMD.
REQ-019 SHALL, in WAIT_CMD, hold cmd_rd_en=0 until cmd_rd_valid=1, then latch cmd_out in that same cycle; a response arrives 1 cycle after request from the buffer, but any latency SHALL be tolerated.
REQ-020 SHALL decode the latched opcode as follows: 00 NOP -> advance, FETCH; 01 WRITE -> ISSUE (wr); 10 READ -> ISSUE (rd); 11 END -> DONE.
REQ-021 SHALL, in ISSUE, drive mst_o_valid=1, mst_o_addr={cmd[61:32],2'b00}, mst_o_wr_data=cmd[31:0], and mst_o_rd0_wr1=1 for WRITE or 0 for READ, holding all of them stable until mst_i_ready=1.
REQ-022 SHALL complete the handshake on the cycle with mst_o_valid=1 and mst_i_ready=1; WRITE then advances to FETCH, while READ goes to WAIT_RD with mst_o_valid=0 next cycle.
REQ-023 SHALL, in WAIT_RD, capture mst_i_rd_data into last_rd_data on mst_i_rd_valid=1, then advance to FETCH.
REQ-024 SHALL, on advance, add 2 to the pointer modulo 2^TRANS_ADDR_WIDTH (each command occupies two buffer words; 8'hFE+2 wraps to 8'h00), and saturate-increment cmd_count at 255.
REQ-025 SHALL, if the advanced pointer equals the start address, set overflow=1 and enter DONE without fetching.
REQ-026 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE; overflow holds until the next start.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL count END commands and NOP commands in cmd_count; END and NOP generate no master request.

Reset
REQ-030 SHALL, when rst_n=0, immediately force state=IDLE and set cmd_rd_en, mst_o_valid, busy, done, overflow, cmd_count, last_rd_data, and all master outputs to 0, including mid-transaction.
REQ-031 SHALL, after reset release, remain in IDLE until a start pulse.

Verification
REQ-032 SHALL verify single write: start_addr=8'h10 with cmd {01, 30'h0000_0004, 32'hDEADBEEF} at 0x10 and END at 0x12 -> mst_o_addr=32'h10, wr_data=DEADBEEF, rd0_wr1=1, done pulse, cmd_count=2.
REQ-033 SHALL verify read: READ addr 30'h8 with mst_i_rd_valid returning 32'hCAFEBABE 3 cycles after ready -> last_rd_data=CAFEBABE, mst_o_valid low during WAIT_RD.
REQ-034 SHALL verify backpressure: mst_i_ready held 0 for 5 cycles -> mst_o_* stable for all 6 cycles, and one handshake only.
REQ-035 SHALL verify wrap and overflow: start_addr=8'hFE with 128 NOPs -> fetch order FE, 00, 02, ...; overflow=1 and done after the 128th, with cmd_count=128.
REQ-036 SHALL verify reset mid-ISSUE: rst_n=0 while mst_o_valid=1 -> all outputs 0 in the same cycle, and IDLE after release.
REQ-037 SHALL verify start while busy: a start pulse during WAIT_CMD -> pointer and cmd_count are unchanged.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Command sequencer: fetches two-word commands from a command buffer and replays
// them as single master bus transactions until an END command or pointer wrap.
module cmd_sequencer #(
  parameter int CMD_WIDTH        = 64,
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [TRANS_ADDR_WIDTH-1:0] start_addr,
  output logic                        cmd_rd_en,
  output logic [TRANS_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                        cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]        cmd_out,
  output logic                        mst_o_valid,
  output logic [ADDR_WIDTH-1:0]       mst_o_addr,
  output logic [DATA_WIDTH-1:0]       mst_o_wr_data,
  output logic                        mst_o_rd0_wr1,
  input  logic                        mst_i_ready,
  input  logic [DATA_WIDTH-1:0]       mst_i_rd_data,
  input  logic                        mst_i_rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [7:0]                  cmd_count,
  output logic [DATA_WIDTH-1:0]       last_rd_data,
  output logic [2:0]                  dbg_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] WAIT_CMD = 3'd2;
  localparam logic [2:0] ISSUE    = 3'd3;
  localparam logic [2:0] WAIT_RD  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  logic [2:0]                  state;
  logic [TRANS_ADDR_WIDTH-1:0] ptr;
  logic [TRANS_ADDR_WIDTH-1:0] start_ptr;
  logic [TRANS_ADDR_WIDTH-1:0] next_ptr;
  logic [CMD_WIDTH-1:0]        cmd_reg;
  logic [1:0]                  op_in;
  logic [1:0]                  op_reg;
  logic [7:0]                  cmd_count_inc;
  logic                        issuing;
  logic                        advance;

  assign op_in         = cmd_out[63:62];
  assign op_reg        = cmd_reg[63:62];
  assign next_ptr      = ptr + TRANS_ADDR_WIDTH'(2);
  assign cmd_count_inc = (cmd_count == 8'hFF) ? cmd_count : cmd_count + 8'd1;
  assign issuing       = (state == ISSUE);

  // A command retires (pointer moves on) after a NOP decode, a WRITE handshake,
  // or the read data of a READ.
  assign advance = ((state == WAIT_CMD) && cmd_rd_valid && (op_in == OP_NOP)) ||
                   (issuing && mst_i_ready && (op_reg == OP_WRITE)) ||
                   ((state == WAIT_RD) && mst_i_rd_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      start_ptr    <= '0;
      cmd_reg      <= '0;
      cmd_count    <= 8'd0;
      overflow     <= 1'b0;
      last_rd_data <= '0;
    end else if (advance) begin
      if (state == WAIT_RD) last_rd_data <= mst_i_rd_data;
      cmd_count <= cmd_count_inc;
      ptr       <= next_ptr;
      // Coming back round to the first command means the buffer holds no END.
      if (next_ptr == start_ptr) begin
        overflow <= 1'b1;
        state    <= DONE;
      end else begin
        state    <= FETCH;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          ptr       <= start_addr;
          start_ptr <= start_addr;
          cmd_count <= 8'd0;
          overflow  <= 1'b0;
          state     <= FETCH;
        end
        FETCH: state <= WAIT_CMD;
        WAIT_CMD: if (cmd_rd_valid) begin
          cmd_reg <= cmd_out;
          if (op_in == OP_END) begin
            cmd_count <= cmd_count_inc;
            state     <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: if (mst_i_ready) state <= WAIT_RD;
        WAIT_RD: ;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Master handshake: the request (valid, addr, wr_data, rd0_wr1) is held stable
  // while valid=1 and ready=0; it is accepted on the rising edge where both are 1.
  assign mst_o_valid   = issuing;
  assign mst_o_addr    = issuing ? ADDR_WIDTH'({cmd_reg[61:32], 2'b00}) : '0;
  assign mst_o_wr_data = issuing ? DATA_WIDTH'(cmd_reg[31:0]) : '0;
  assign mst_o_rd0_wr1 = issuing && (op_reg == OP_WRITE);

  assign cmd_rd_en = (state == FETCH);
  assign cmd_addr  = ptr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: buffer/master responder, sequence-level reference model
// feeding expected queues, and a negedge monitor that pops and compares.
module tb_cmd_sequencer;

  logic        clk, rst_n, start;
  logic [7:0]  start_addr, cmd_addr;
  logic        cmd_rd_en, cmd_rd_valid;
  logic [63:0] cmd_out;
  logic        mst_o_valid, mst_o_rd0_wr1, mst_i_ready, mst_i_rd_valid;
  logic [31:0] mst_o_addr, mst_o_wr_data, mst_i_rd_data, last_rd_data;
  logic        busy, done, overflow;
  logic [7:0]  cmd_count;
  logic [2:0]  dbg_state;

  cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr), .cmd_rd_valid(cmd_rd_valid),
    .cmd_out(cmd_out), .mst_o_valid(mst_o_valid), .mst_o_addr(mst_o_addr),
    .mst_o_wr_data(mst_o_wr_data), .mst_o_rd0_wr1(mst_o_rd0_wr1),
    .mst_i_ready(mst_i_ready), .mst_i_rd_data(mst_i_rd_data),
    .mst_i_rd_valid(mst_i_rd_valid), .busy(busy), .done(done),
    .overflow(overflow), .cmd_count(cmd_count), .last_rd_data(last_rd_data),
    .dbg_state(dbg_state)
  );

  logic [63:0] mem [256];
  logic [64:0] exp_q[$];     // {rd0_wr1, addr, wr_data}
  logic [7:0]  fetch_q[$];
  logic [8:0]  stat_q[$];    // {overflow, cmd_count}
  logic [31:0] exp_last_rd;
  int          n_checks, n_fail;
  int          done_seen, hs_count;
  int          bp_left, rd_lat_fix;
  bit          rd_fix_en;
  logic [31:0] rd_fix;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  task automatic flush_model();
    exp_q.delete();
    fetch_q.delete();
    stat_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Walks the command list from s: one fetch per command, one master request per
  // WRITE/READ, stops at END or when the pointer comes back to s.
  task automatic model_seq(input logic [7:0] s);
    int          p, cnt;
    logic        ov;
    logic [63:0] c;
    p = int'(s); cnt = 0; ov = 1'b0;
    while (1) begin
      fetch_q.push_back(8'(p));
      c = mem[p];
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (c[63:62] == 2'b11) break;
      if (c[63:62] != 2'b00)
        exp_q.push_back({c[63:62] == 2'b01, c[61:32], 2'b00, c[31:0]});
      p = (p + 2) % 256;
      if (p == int'(s)) begin
        ov = 1'b1;
        break;
      end
    end
    stat_q.push_back({ov, 8'(cnt)});
  endtask

  // ---------------- responder + monitor ----------------
  initial begin : bfm
    logic [7:0]  pa;
    logic [64:0] held;
    bit          pend, rpend, hold_v;
    int          cnt, rcnt;
    logic [8:0]  st;
    cmd_rd_valid = 1'b0; cmd_out = '0;
    mst_i_ready = 1'b0; mst_i_rd_valid = 1'b0; mst_i_rd_data = '0;
    pend = 0; rpend = 0; hold_v = 0; cnt = 0; rcnt = 0; pa = '0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; rpend = 0; hold_v = 0;
        cmd_rd_valid = 1'b0; mst_i_rd_valid = 1'b0; mst_i_ready = 1'b0;
        continue;
      end
      // command buffer
      cmd_rd_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          cmd_rd_valid = 1'b1;
          cmd_out = mem[pa];
          pend = 0;
        end else cnt--;
      end
      if (cmd_rd_en) begin
        if (fetch_q.size() == 0) fail_evt("unexpected_fetch");
        else check("fetch_addr", cmd_addr, fetch_q.pop_front());
        pa = cmd_addr; pend = 1; cnt = $urandom_range(0, 2);
      end
      // read data return
      mst_i_rd_valid = 1'b0;
      if (rpend) begin
        check("valid_low_wait_rd", mst_o_valid, 1'b0);
        rcnt--;
        if (rcnt == 0) begin
          mst_i_rd_valid = 1'b1;
          mst_i_rd_data = rd_fix_en ? rd_fix : $urandom;
          exp_last_rd = mst_i_rd_data;
          rpend = 0;
        end
      end
      // master request
      if (hold_v) begin
        check("hold_valid", mst_o_valid, 1'b1);
        check("hold_payload", {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data}, held);
        hold_v = 0;
      end
      if (mst_o_valid) begin
        if (bp_left > 1) begin mst_i_ready = 1'b0; bp_left--; end
        else if (bp_left == 1) begin mst_i_ready = 1'b1; bp_left--; end
        else mst_i_ready = ($urandom_range(0, 3) != 0);
        if (mst_i_ready) begin
          hs_count++;
          if (exp_q.size() == 0) fail_evt("unexpected_request");
          else check("request", {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data}, exp_q.pop_front());
          if (!mst_o_rd0_wr1) begin
            rpend = 1;
            rcnt = (rd_lat_fix > 0) ? rd_lat_fix : $urandom_range(1, 4);
          end
        end else begin
          hold_v = 1;
          held = {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data};
        end
      end else mst_i_ready = 1'($urandom_range(0, 1));
      // completion
      if (done) begin
        if (stat_q.size() == 0) fail_evt("unexpected_done");
        else begin
          st = stat_q.pop_front();
          check("done_cmd_count", cmd_count, st[7:0]);
          check("done_overflow", overflow, st[8]);
          check("done_last_rd", last_rd_data, exp_last_rd);
          check("busy_in_done", busy, 1'b1);
        end
        done_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_seq(input logic [7:0] s, input bit busy_start, input string tag);
    int d0, n;
    model_seq(s);
    d0 = done_seen;
    @(negedge clk); start = 1'b1; start_addr = s;
    @(negedge clk); start = 1'b0;
    if (busy_start) begin
      @(negedge clk); start = 1'b1; start_addr = s + 8'd6;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (done_seen == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_completed"}, n < 5000, 1'b1);
    check({tag, "_reqs_left"}, exp_q.size(), 0);
    check({tag, "_fetches_left"}, fetch_q.size(), 0);
    check({tag, "_status_left"}, stat_q.size(), 0);
    if (n >= 5000) apply_reset();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; bp_left = 0;
    flush_model();
    exp_last_rd = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_end();
    for (int i = 0; i < 256; i++) mem[i] = {2'b11, 30'($urandom), 32'($urandom)};
  endtask

  task automatic fill_random();
    logic [1:0] op;
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 30) ? 2'b00 : (r < 60) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
      mem[i] = {op, 30'($urandom), 32'($urandom)};
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    int h0, n;
    n_checks = 0; n_fail = 0; done_seen = 0; hs_count = 0;
    bp_left = 0; rd_lat_fix = 0; rd_fix_en = 0; rd_fix = '0; exp_last_rd = '0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0;
    fill_end();
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_rd_en", cmd_rd_en, 1'b0);
    check("rst_mst_valid", mst_o_valid, 1'b0);
    check("rst_status", {done, overflow, cmd_count, last_rd_data}, '0);
    check("rst_mst_payload", {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_after_release", {busy, cmd_rd_en, mst_o_valid}, 3'b000);
    end

    // single write then END
    mem[8'h10] = {2'b01, 30'h0000_0004, 32'hDEADBEEF};
    mem[8'h12] = {2'b11, 30'h0, 32'h0};
    h0 = hs_count;
    run_seq(8'h10, 0, "single_write");
    check("sw_cmd_count", cmd_count, 8'd2);
    check("sw_handshakes", hs_count - h0, 1);

    // read with data 3 cycles after ready
    mem[8'h20] = {2'b10, 30'h0000_0008, 32'h1234_5678};
    mem[8'h22] = {2'b11, 30'h0, 32'h0};
    rd_lat_fix = 3; rd_fix_en = 1; rd_fix = 32'hCAFEBABE;
    run_seq(8'h20, 0, "read");
    check("rd_last_rd_data", last_rd_data, 32'hCAFEBABE);
    rd_lat_fix = 0; rd_fix_en = 0;

    // backpressure: ready low 5 cycles, then high
    mem[8'h50] = {2'b01, 30'h0ABC_DEF0, 32'h0BAD_F00D};
    mem[8'h52] = {2'b11, 30'h0, 32'h0};
    bp_left = 6;
    h0 = hs_count;
    run_seq(8'h50, 0, "backpressure");
    check("bp_handshakes", hs_count - h0, 1);

    // wrap from FE with 128 NOPs
    for (int i = 0; i < 256; i++) mem[i] = {2'b00, 30'($urandom), 32'($urandom)};
    run_seq(8'hFE, 0, "wrap");
    check("wrap_cmd_count", cmd_count, 8'd128);
    check("wrap_overflow", overflow, 1'b1);

    // start pulse during WAIT_CMD
    fill_end();
    mem[8'h30] = {2'b01, 30'h11, 32'hA5A5_A5A5};
    mem[8'h32] = {2'b10, 30'h22, 32'h5A5A_5A5A};
    mem[8'h34] = {2'b11, 30'h0, 32'h0};
    run_seq(8'h30, 1, "busy_start");
    check("busy_start_cmd_count", cmd_count, 8'd3);
    check("busy_start_overflow", overflow, 1'b0);

    // randomized command lists
    for (int k = 0; k < 30; k++) begin
      fill_random();
      run_seq(8'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    // reset while a request is outstanding
    fill_end();
    mem[8'h40] = {2'b01, 30'h123, 32'h5555_AAAA};
    bp_left = 100000;
    model_seq(8'h40);
    @(negedge clk); start = 1'b1; start_addr = 8'h40;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!mst_o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_issue_reached", mst_o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", mst_o_valid, 1'b0);
    check("mid_rst_busy", {busy, cmd_rd_en}, 2'b00);
    check("mid_rst_status", {done, overflow, cmd_count, last_rd_data}, '0);
    check("mid_rst_payload", {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data}, '0);
    flush_model();
    bp_left = 0; exp_last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_after_mid_rst", {busy, cmd_rd_en, mst_o_valid}, 3'b000);
    end

    fill_random();
    run_seq(8'h80, 0, "after_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
